// File: rtl/spatz_rsp_collector_if.sv
// Return-path bundle between the Spatz controller/units and the response collector.
// Handshake rule for every valid/ready pair here: a transfer happens on a rising clock
// edge where valid and ready are both high; a source holding valid keeps its payload
// stable until that edge, and ready may depend combinationally on valid.
interface spatz_rsp_collector_if #(
    parameter int unsigned NrIds     = 4,
    parameter int unsigned XIdWidth  = 5,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned IdWidth = (NrIds > 1) ? $clog2(NrIds) : 1;

    typedef logic [IdWidth-1:0] spatz_id_t;

    typedef struct packed {
        spatz_id_t            id;
        logic [DataWidth-1:0] result;
        logic [4:0]           rd;
        logic                 wb;
    } vfu_rsp_t;

    typedef struct packed {
        spatz_id_t id;
        logic      exc;
    } vlsu_rsp_t;

    typedef struct packed {
        spatz_id_t id;
    } vsldu_rsp_t;

    // ID allocation towards the controller
    logic                 alloc_valid_i;
    logic                 alloc_ready_o;
    spatz_id_t            alloc_id_o;
    logic [XIdWidth-1:0]  alloc_xintf_id_i;
    logic [4:0]           alloc_rd_i;
    logic                 alloc_wb_i;

    // Unit completions
    logic                 vfu_rsp_valid_i;
    logic                 vfu_rsp_ready_o;
    vfu_rsp_t             vfu_rsp_i;
    logic                 vlsu_rsp_valid_i;
    logic                 vlsu_rsp_ready_o;
    vlsu_rsp_t            vlsu_rsp_i;
    logic                 vsldu_rsp_valid_i;
    logic                 vsldu_rsp_ready_o;
    vsldu_rsp_t           vsldu_rsp_i;

    // Result towards the scalar core X-interface
    logic                 xif_valid_o;
    logic                 xif_ready_i;
    logic [XIdWidth-1:0]  xif_id_o;
    logic [DataWidth-1:0] xif_data_o;
    logic [4:0]           xif_rd_o;
    logic                 xif_we_o;
    logic                 xif_exc_o;

    logic                 busy_o;

    // Collector side
    modport slave (
        input  alloc_valid_i, alloc_xintf_id_i, alloc_rd_i, alloc_wb_i,
        output alloc_ready_o, alloc_id_o,
        input  vfu_rsp_valid_i, vfu_rsp_i,
        output vfu_rsp_ready_o,
        input  vlsu_rsp_valid_i, vlsu_rsp_i,
        output vlsu_rsp_ready_o,
        input  vsldu_rsp_valid_i, vsldu_rsp_i,
        output vsldu_rsp_ready_o,
        output xif_valid_o, xif_id_o, xif_data_o, xif_rd_o, xif_we_o, xif_exc_o,
        input  xif_ready_i,
        output busy_o
    );

    // Controller / unit / core side
    modport master (
        output alloc_valid_i, alloc_xintf_id_i, alloc_rd_i, alloc_wb_i,
        input  alloc_ready_o, alloc_id_o,
        output vfu_rsp_valid_i, vfu_rsp_i,
        input  vfu_rsp_ready_o,
        output vlsu_rsp_valid_i, vlsu_rsp_i,
        input  vlsu_rsp_ready_o,
        output vsldu_rsp_valid_i, vsldu_rsp_i,
        input  vsldu_rsp_ready_o,
        input  xif_valid_o, xif_id_o, xif_data_o, xif_rd_o, xif_we_o, xif_exc_o,
        output xif_ready_i,
        input  busy_o
    );
endinterface

// File: rtl/spatz_rsp_collector.sv
// Spatz response collector: hands out instruction IDs, remembers the core context of each
// ID, merges VFU/VLSU/VSLDU completions into one registered X-interface result stream.
// Optional macro SPATZ_RSP_RR_ARB_EN selects round-robin arbitration between the three
// units; without it the units are served in fixed priority VFU > VLSU > VSLDU.
module spatz_rsp_collector #(
    parameter int unsigned NrIds     = 4,
    parameter int unsigned XIdWidth  = 5,
    parameter int unsigned DataWidth = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    spatz_rsp_collector_if.slave bus
);
    localparam int unsigned IdWidth = (NrIds > 1) ? $clog2(NrIds) : 1;

    // ---------------------------------------------------------------------------------
    // ID table
    // ---------------------------------------------------------------------------------
    logic [NrIds-1:0]    tbl_valid_q;
    logic [XIdWidth-1:0] tbl_xid_q [NrIds];
    logic [4:0]          tbl_rd_q  [NrIds];
    logic [NrIds-1:0]    tbl_wb_q;

    logic [IdWidth-1:0]  free_id;
    logic                any_free;
    logic                alloc_fire;

    // Lowest free index; scanning downwards lets the lowest match overwrite the others.
    always_comb begin
        free_id  = '0;
        any_free = 1'b0;
        for (int i = NrIds - 1; i >= 0; i--) begin
            if (!tbl_valid_q[i]) begin
                free_id  = IdWidth'(i);
                any_free = 1'b1;
            end
        end
    end

    // Allocation only looks at the pre-edge valid bits, so an ID freed this cycle is
    // not offered until the next one.
    assign bus.alloc_ready_o = any_free;
    assign bus.alloc_id_o    = free_id;
    assign alloc_fire        = bus.alloc_valid_i & any_free;

    // ---------------------------------------------------------------------------------
    // Completion arbitration
    // ---------------------------------------------------------------------------------
    logic [2:0]           req;
    logic [2:0]           gnt;
    logic                 slot_free;
    logic                 win_fire;
    logic                 win_hit;
    logic [IdWidth-1:0]   win_id;
    logic [DataWidth-1:0] win_data;
    logic                 win_exc;
    logic                 win_vfu_wb;

    // Output register can take a new result when empty or being drained this cycle.
    assign slot_free = ~bus.xif_valid_o | bus.xif_ready_i;
    assign req       = {bus.vsldu_rsp_valid_i, bus.vlsu_rsp_valid_i, bus.vfu_rsp_valid_i};

`ifdef SPATZ_RSP_RR_ARB_EN
    // Unit index that currently holds top priority: 0 VFU, 1 VLSU, 2 VSLDU.
    logic [1:0] rr_ptr_q;

    // Rotating priority starting at the pointer unit, wrapping VSLDU -> VFU.
    always_comb begin
        gnt = '0;
        case (rr_ptr_q)
            2'd1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    // Pointer moves to the unit after the winner on every accepted completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= 2'd0;
        end else if (win_fire) begin
            if (gnt[0])      rr_ptr_q <= 2'd1;
            else if (gnt[1]) rr_ptr_q <= 2'd2;
            else             rr_ptr_q <= 2'd0;
        end
    end
`else
    // Fixed priority VFU > VLSU > VSLDU.
    always_comb begin
        gnt    = '0;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
        gnt[2] = req[2] & ~req[1] & ~req[0];
    end
`endif

    // Only the winner sees ready, and only when the output register can take it.
    assign bus.vfu_rsp_ready_o   = gnt[0] & slot_free;
    assign bus.vlsu_rsp_ready_o  = gnt[1] & slot_free;
    assign bus.vsldu_rsp_ready_o = gnt[2] & slot_free;
    assign win_fire              = (|gnt) & slot_free;

    // Payload of the winning unit; VLSU/VSLDU carry no data and never write back.
    always_comb begin
        win_id     = '0;
        win_data   = '0;
        win_exc    = 1'b0;
        win_vfu_wb = 1'b0;
        if (gnt[0]) begin
            win_id     = bus.vfu_rsp_i.id;
            win_data   = bus.vfu_rsp_i.result;
            win_vfu_wb = bus.vfu_rsp_i.wb;
        end else if (gnt[1]) begin
            win_id     = bus.vlsu_rsp_i.id;
            win_exc    = bus.vlsu_rsp_i.exc;
        end else if (gnt[2]) begin
            win_id     = bus.vsldu_rsp_i.id;
        end
    end

    // A completion for an unallocated ID is swallowed without producing a result.
    assign win_hit = tbl_valid_q[win_id];

    // The VFU echoes rd, but the destination register always comes from the table.
    logic unused_vfu_rd;
    assign unused_vfu_rd = ^bus.vfu_rsp_i.rd;

    // Valid bits: set on allocation, cleared when the matching completion is accepted.
    // The two IDs can never coincide (one is free, the other allocated).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tbl_valid_q <= '0;
        end else begin
            if (alloc_fire) begin
                tbl_valid_q[free_id] <= 1'b1;
            end
            if (win_fire && win_hit) begin
                tbl_valid_q[win_id] <= 1'b0;
            end
        end
    end

    // Per-ID core context, captured on allocation; meaningless while the entry is free.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            tbl_xid_q[free_id] <= bus.alloc_xintf_id_i;
            tbl_rd_q[free_id]  <= bus.alloc_rd_i;
            tbl_wb_q[free_id]  <= bus.alloc_wb_i;
        end
    end

    // ---------------------------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------------------------
    logic                 xif_valid_q;
    logic [XIdWidth-1:0]  xif_id_q;
    logic [DataWidth-1:0] xif_data_q;
    logic [4:0]           xif_rd_q;
    logic                 xif_we_q;
    logic                 xif_exc_q;

    // Load on an accepted completion, drop after the core takes it, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xif_valid_q <= 1'b0;
            xif_id_q    <= '0;
            xif_data_q  <= '0;
            xif_rd_q    <= '0;
            xif_we_q    <= 1'b0;
            xif_exc_q   <= 1'b0;
        end else if (win_fire && win_hit) begin
            xif_valid_q <= 1'b1;
            xif_id_q    <= tbl_xid_q[win_id];
            xif_data_q  <= win_data;
            xif_rd_q    <= tbl_rd_q[win_id];
            xif_we_q    <= tbl_wb_q[win_id] & win_vfu_wb;
            xif_exc_q   <= win_exc;
        end else if (bus.xif_ready_i) begin
            xif_valid_q <= 1'b0;
        end
    end

    assign bus.xif_valid_o = xif_valid_q;
    assign bus.xif_id_o    = xif_id_q;
    assign bus.xif_data_o  = xif_data_q;
    assign bus.xif_rd_o    = xif_rd_q;
    assign bus.xif_we_o    = xif_we_q;
    assign bus.xif_exc_o   = xif_exc_q;

    assign bus.busy_o = (|tbl_valid_q) | xif_valid_q;

`ifndef SYNTHESIS
    // A unit completing an ID that was never handed out points at a controller bug.
    a_rsp_id_allocated : assert property (@(posedge clk_i) disable iff (rst_i)
        win_fire |-> win_hit);
`endif

endmodule
